// File: rtl/branch_redirect_ctrl.sv
// Fetch PC sequencer: redirects on EX-stage taken branches, waits out the I-mem refill,
// and halts on misaligned targets. Optional `BRANCH_STATS_EN adds taken/refill counters.
module branch_redirect_ctrl #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          REFILL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        ex_valid,
  input  logic        isBranchTaken,
  input  logic [31:0] branchPC,
  output logic [31:0] pc,
  output logic        fetch_valid,
  output logic        flush_if_of,
  output logic        flush_of_ex,
  output logic        busy,
  output logic        fault,
`ifdef BRANCH_STATS_EN
  output logic [31:0] taken_count,
  output logic [31:0] refill_cycles,
`endif
  output logic [1:0]  dbgState
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    REFILL = 2'd1,
    HALT   = 2'd2
  } state_t;

  state_t      state, stateNext;
  logic [3:0]  cnt, cntNext;
  logic [31:0] pcNext;
  logic        faultNext;
  logic        accept;
  logic        aligned;

  // Handshake: a taken branch is consumed only when EX holds a real instruction,
  // the pipeline is not stalled and fetch is running; otherwise EX re-presents it.
  assign accept  = ex_valid & isBranchTaken & ~stall & (state == RUN);
  assign aligned = (branchPC[1:0] == 2'b00);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt   <= 4'd0;
      pc    <= RESET_PC;
      fault <= 1'b0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      pc    <= pcNext;
      fault <= faultNext;
    end
  end

  always_comb begin
    stateNext   = state;
    cntNext     = cnt;
    pcNext      = pc;
    faultNext   = fault;
    flush_if_of = 1'b0;
    flush_of_ex = 1'b0;
    case (state)
      RUN: begin
        if (accept) begin
          flush_if_of = 1'b1;
          flush_of_ex = 1'b1;
          if (aligned) begin
            pcNext = branchPC;
            if (REFILL_CYCLES != 0) begin
              stateNext = REFILL;
              cntNext   = 4'(REFILL_CYCLES - 1);
            end
          end else begin
            faultNext = 1'b1;
            stateNext = HALT;
          end
        end else if (!stall) begin
          pcNext = pc + 32'd4;
        end
      end
      REFILL: begin
        // Refill models memory latency, so it counts down even while stalled.
        if (cnt == 4'd0) begin
          stateNext = RUN;
        end else begin
          cntNext = cnt - 4'd1;
        end
      end
      HALT: begin
        stateNext = HALT;
      end
      default: begin
        stateNext = RUN;
      end
    endcase
  end

  assign fetch_valid = (state == RUN);
  assign busy        = (state == REFILL);
  assign dbgState    = state;

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      taken_count   <= 32'd0;
      refill_cycles <= 32'd0;
    end else begin
      if (accept && aligned && (taken_count != 32'hFFFF_FFFF))
        taken_count <= taken_count + 32'd1;
      if ((state == REFILL) && (refill_cycles != 32'hFFFF_FFFF))
        refill_cycles <= refill_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Self-checking bench for branch_redirect_ctrl: spec-level cycle model feeds an expected
// queue each driven cycle; registered outputs are popped and compared after the edge.
module tb_branch_redirect_ctrl;

  localparam logic [31:0] RESET_PC      = 32'h0000_0000;
  localparam int          REFILL_CYCLES = 2;
  localparam int          W             = 37;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        ex_valid;
  logic        isBranchTaken;
  logic [31:0] branchPC;
  logic [31:0] pc;
  logic        fetch_valid;
  logic        flush_if_of;
  logic        flush_of_ex;
  logic        busy;
  logic        fault;
  logic [1:0]  dbgState;
`ifdef BRANCH_STATS_EN
  logic [31:0] taken_count;
  logic [31:0] refill_cycles;
`endif

  branch_redirect_ctrl #(
    .RESET_PC      (RESET_PC),
    .REFILL_CYCLES (REFILL_CYCLES)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .ex_valid      (ex_valid),
    .isBranchTaken (isBranchTaken),
    .branchPC      (branchPC),
    .pc            (pc),
    .fetch_valid   (fetch_valid),
    .flush_if_of   (flush_if_of),
    .flush_of_ex   (flush_of_ex),
    .busy          (busy),
    .fault         (fault),
`ifdef BRANCH_STATS_EN
    .taken_count   (taken_count),
    .refill_cycles (refill_cycles),
`endif
    .dbgState      (dbgState)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] exp_q[$];

  // reference model state (0=RUN, 1=REFILL, 2=HALT)
  logic [1:0]  m_state;
  logic [3:0]  m_cnt;
  logic [31:0] m_pc;
  logic        m_fault;
  logic [31:0] m_taken;
  logic [31:0] m_refill;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check combinational flushes, advance model, compare after edge.
  task automatic step(input logic rst, input logic st, input logic ev, input logic tk,
                      input logic [31:0] bpc);
    logic         acc;
    logic [W-1:0] exp_v;
    logic [W-1:0] obs_v;
    @(negedge clk);
    reset = rst; stall = st; ex_valid = ev; isBranchTaken = tk; branchPC = bpc;
    #1;
    acc = ev & tk & ~st & (m_state == 2'd0);
    check("flush_if_of", 64'(flush_if_of), 64'(acc));
    check("flush_of_ex", 64'(flush_of_ex), 64'(acc));
    if (rst) begin
      m_state = 2'd0; m_cnt = 4'd0; m_pc = RESET_PC; m_fault = 1'b0;
      m_taken = 32'd0; m_refill = 32'd0;
    end else begin
      if (m_state == 2'd1 && m_refill != 32'hFFFF_FFFF) m_refill = m_refill + 1;
      case (m_state)
        2'd0: begin
          if (acc && bpc[1:0] == 2'b00) begin
            m_pc = bpc;
            if (m_taken != 32'hFFFF_FFFF) m_taken = m_taken + 1;
            if (REFILL_CYCLES != 0) begin
              m_state = 2'd1; m_cnt = 4'(REFILL_CYCLES - 1);
            end
          end else if (acc) begin
            m_fault = 1'b1; m_state = 2'd2;
          end else if (!st) begin
            m_pc = m_pc + 32'd4;
          end
        end
        2'd1: begin
          if (m_cnt == 4'd0) m_state = 2'd0;
          else m_cnt = m_cnt - 4'd1;
        end
        default: ;
      endcase
    end
    exp_q.push_back({m_state, m_fault, (m_state == 2'd1), (m_state == 2'd0), m_pc});
    @(posedge clk);
    #1;
    obs_v = {dbgState, fault, busy, fetch_valid, pc};
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 64'(1), 64'(0));
    end else begin
      exp_v = exp_q.pop_front();
      check("regs{state,fault,busy,fv,pc}", 64'(obs_v), 64'(exp_v));
    end
`ifdef BRANCH_STATS_EN
    check("taken_count", 64'(taken_count), 64'(m_taken));
    check("refill_cycles", 64'(refill_cycles), 64'(m_refill));
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic branch_to(input logic [31:0] tgt);
    step(1'b0, 1'b0, 1'b1, 1'b1, tgt);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; ex_valid = 1'b0; isBranchTaken = 1'b0; branchPC = 32'h0;
    m_state = 2'd0; m_cnt = 4'd0; m_pc = RESET_PC; m_fault = 1'b0;
    m_taken = 32'd0; m_refill = 32'd0;

    // reset then sequential fetch
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    check("reset_pc", 64'(pc), 64'(RESET_PC));
    check("reset_fetch_valid", 64'(fetch_valid), 64'(1));
    check("reset_busy", 64'(busy), 64'(0));
    idle(3);
    check("pc_after_3", 64'(pc), 64'h0C);
    idle(1);

    // taken branch at 0x10 to 0x100; ignored branch requests during refill
    branch_to(32'h100);
    check("pc_redirect", 64'(pc), 64'h100);
    check("busy_refill", 64'(busy), 64'(1));
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h500);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h600);
    check("refill_done_valid", 64'(fetch_valid), 64'(1));
    check("refill_pc_held", 64'(pc), 64'h100);
    idle(1);
    check("pc_after_refill", 64'(pc), 64'h104);

    // branch held under stall, accepted on release
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 32'h200);
    check("stall_pc_frozen", 64'(pc), 64'h104);
    branch_to(32'h200);
    check("stall_release_redirect", 64'(pc), 64'h200);
    idle(3);

    // random mix of stalls, bubbles and aligned branches
    for (int i = 0; i < 60; i++)
      step(1'b0, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) == 0), {$urandom_range(0, 32'h0FFF_FFFF), 2'b00} & 32'hFFFF_FFFC);

    // wrap at top of address space
    idle(3);
    branch_to(32'hFFFF_FFFC);
    idle(2);
    check("pc_top", 64'(pc), 64'hFFFF_FFFC);
    idle(1);
    check("pc_wrap", 64'(pc), 64'h0);

    // reset in the middle of refill
    branch_to(32'h300);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    check("midrefill_reset_pc", 64'(pc), 64'(RESET_PC));
    check("midrefill_reset_busy", 64'(busy), 64'(0));
    idle(2);

    // misaligned target halts fetch until reset
    branch_to(32'h102);
    check("halt_fault", 64'(fault), 64'(1));
    check("halt_pc_held", 64'(pc), 64'h8);
    for (int i = 0; i < 10; i++)
      step(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b1, 32'h400);
    check("halt_fetch_valid", 64'(fetch_valid), 64'(0));
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    check("halt_reset_fault", 64'(fault), 64'(0));
    check("halt_reset_pc", 64'(pc), 64'(RESET_PC));

    // five aligned branches back to back
    for (int i = 0; i < 5; i++) begin
      branch_to(32'h1000 + 32'(i) * 32'h40);
      idle(2);
    end
`ifdef BRANCH_STATS_EN
    check("stats_taken_5", 64'(taken_count), 64'd5);
    check("stats_refill_10", 64'(refill_cycles), 64'd10);
`endif
    idle(2);

    if (exp_q.size() != 0) check("scoreboard_leftover", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
- Fetch-side sequencer for the 5-stage SimpleRISC pipeline.
- Owns the fetch PC register and consumes EX-stage branch resolution (isBranchTaken, branchPC).
- On a taken branch it squashes the IF/OF and OF/EX pipeline registers and redirects the PC.
- It then holds fetch invalid for a fixed instruction-memory refill latency; a misaligned branch target halts fetch.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
REFILL_CYCLES, 2, cycles fetch_valid stays low after a redirect (0..15; 0 = no refill wait)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  global pipeline stall from hazard/memory unit
ex_valid  input  1  EX stage holds a real instruction (not a bubble)
isBranchTaken  input  1  branch taken, from EX-stage branch resolution
branchPC  input  32  branch target, from EX-stage branch resolution
pc  output  32  current fetch PC (registered)
fetch_valid  output  1  pc is a valid fetch address this cycle
flush_if_of  output  1  load bubble into IF/OF register at next edge (combinational)
flush_of_ex  output  1  load bubble into OF/EX register at next edge (combinational)
busy  output  1  controller in REFILL state
fault  output  1  sticky misaligned-target fault (registered)

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- States: RUN, REFILL, HALT; 4-bit refill counter cnt.
- Reset values:
  - pc=RESET_PC, state=RUN, cnt=0, fault=0.
  - fetch_valid=1, busy=0, flush_*=0.
  - Reset mid-REFILL or in HALT returns to RUN at RESET_PC next cycle.
- accept = ex_valid & isBranchTaken & ~stall & (state==RUN). A taken branch while stall=1 is not accepted: EX is frozen and re-presents it.
- RUN, no accept:
  - stall=0: pc <= pc+4, modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
  - stall=1: pc holds.
  - fetch_valid=1.
- RUN, accept:
  - flush_if_of=flush_of_ex=1 in the same cycle (combinational).
  - branchPC[1:0]==0:
    - pc <= branchPC; branch overrides the +4 increment.
    - REFILL_CYCLES==0: stay RUN.
    - Else go to REFILL with cnt <= REFILL_CYCLES-1.
  - branchPC[1:0]!=0: pc holds, fault <= 1, go to HALT.
- REFILL:
  - fetch_valid=0, busy=1, pc holds.
  - cnt decrements every cycle regardless of stall, since it models memory latency.
  - When cnt==0: RUN next edge.
  - ex_valid/isBranchTaken ignored; they are bubbles after the flush.
- HALT:
  - fetch_valid=0, flush_*=0, pc frozen, fault=1.
  - Exit only via reset.
- flush_* are never asserted outside an accept cycle.
- Accept-to-first-valid-fetch latency at branchPC is REFILL_CYCLES+1 edges.

Optional Feature:
- Macro BRANCH_STATS_EN.
- When defined, adds two outputs:
  - taken_count [31:0]: increments on every accept with an aligned target.
  - refill_cycles [31:0]: increments on every cycle in REFILL.
- Both reset to 0, saturate at 32'hFFFF_FFFF and ignore stall.
- When undefined, neither the ports nor the counters exist; all other behaviour is identical.

Test Plan:
- Reset then 3 cycles, stall=0, no branch -> pc 0x0, 0x4, 0x8, 0xC; fetch_valid=1; flush_*=0.
- At pc=0x10, ex_valid=1, isBranchTaken=1, branchPC=0x100, REFILL_CYCLES=2 -> flush_* high that cycle only; pc=0x100; fetch_valid=0 for 2 cycles, busy=1; then fetch_valid=1, pc=0x104 next.
- Taken branch to 0x200 with stall=1 for 3 cycles, then stall=0 -> no flush and pc frozen during stall; accept, flush and redirect to 0x200 on the release cycle.
- branchPC=0x102 taken -> flush_* pulse, fault=1, fetch_valid=0, pc unchanged; stays halted 10 cycles; reset -> pc=RESET_PC, fault=0.
- pc=0xFFFF_FFFC, stall=0 -> pc=0x0000_0000. Separately, reset asserted mid-REFILL -> RUN, pc=RESET_PC, busy=0 next cycle.
- BRANCH_STATS_EN defined, REFILL_CYCLES=2, 5 aligned taken branches -> taken_count=5, refill_cycles=10.
